// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter.
// FSM state encoding, port id type, port count.
package ram_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Two-way round-robin pick, purely combinational.
// In: req_i[1:0], last_i. Out: gnt_o (winner id), any_o.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  port_id_t             last_i,
  output port_id_t             gnt_o,
  output logic                 any_o
);

  assign any_o = |req_i;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    gnt_o = 1'b0;
    if (&req_i) begin
      gnt_o = ~last_i;
    end else if (req_i[1]) begin
      gnt_o = 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between fetch (port 0) and load/store (port 1).
// Ports: clk, rst_n, req/we/addr/wdata/rdata/ack per port, mem_wen, mem_addr, mem_data.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ack1,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  state_t                state_q;
  port_id_t              win_q;
  port_id_t              last_q;
  logic                  we_q;
  logic                  wen_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;

  port_id_t              gnt;
  logic                  any;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  rr_pick2 u_pick (
    .req_i  ({req1, req0}),
    .last_i (last_q),
    .gnt_o  (gnt),
    .any_o  (any)
  );

  assign we_d    = gnt ? we1    : we0;
  assign addr_d  = gnt ? addr1  : addr0;
  assign wdata_d = gnt ? wdata1 : wdata0;

  // Reset is synchronous, but a write caught in ACCESS when rst_n
  // drops must not reach the RAM, so the enable is gated directly.
  assign mem_wen  = wen_q & rst_n;
  assign mem_addr = addr_q;
  assign mem_data = mem_wen ? wdata_q : {DATA_WIDTH{1'bz}};

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      wen_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          if (any) begin
            win_q   <= gnt;
            we_q    <= we_d;
            wen_q   <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          wen_q <= 1'b0;
          if (!we_q) begin
            if (win_q) rdata1_q <= mem_data;
            else       rdata0_q <= mem_data;
          end
          ack0_q  <= ~win_q;
          ack1_q  <= win_q;
          state_q <= DONE;
        end
        DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          last_q  <= win_q;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM.
// Checks reset state, reads, writes, ties, late requests, reset abort.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, wdata0, addr1, wdata1;
  logic [3:0] rdata0, rdata1;
  logic       ack0, ack1;
  logic       mem_wen;
  logic [3:0] mem_addr;
  wire  [3:0] mem_data;

  logic [3:0] ram [16];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .rdata0   (rdata0),
    .ack0     (ack0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .rdata1   (rdata1),
    .ack1     (ack1),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  assign mem_data = mem_wen ? 4'bzzzz : ram[mem_addr];

  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr] <= mem_data;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // With the RAM driving whenever mem_wen is low, any arbiter drive
  // at that time would disturb the value seen on the bus.
  always @(negedge clk) begin
    if (!mem_wen) chk("bus_release", {28'd0, mem_data}, {28'd0, ram[mem_addr]});
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 4'h0;
    ram[1] = 4'b0011;
    ram[2] = 4'b1100;
    ram[3] = 4'b1010;
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    tick(); tick(); tick();
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwen", mem_wen, 0);
    rst_n = 1'b1;
    tick();

    // tie from reset: port 0 first
    req0 = 1; addr0 = 4'd1; req1 = 1; addr1 = 4'd2;
    tick();
    chk("tie1_addr_a", mem_addr, 1);
    chk("tie1_wen_a", mem_wen, 0);
    chk("tie1_ack0_a", ack0, 0);
    tick();
    chk("tie1_ack0", ack0, 1);
    chk("tie1_ack1_n", ack1, 0);
    chk("tie1_rd0", rdata0, 4'b0011);
    req0 = 0;
    tick();
    chk("tie1_idle_ack0", ack0, 0);
    chk("tie1_idle_ack1", ack1, 0);
    tick();
    chk("tie1_addr_b", mem_addr, 2);
    chk("tie1_ack1_b", ack1, 0);
    tick();
    chk("tie1_ack1", ack1, 1);
    chk("tie1_ack0_n", ack0, 0);
    chk("tie1_rd1", rdata1, 4'b1100);
    req1 = 0;
    tick();

    // single read on port 0
    req0 = 1; addr0 = 4'd3;
    tick();
    chk("rd_addr", mem_addr, 3);
    chk("rd_ack0_early", ack0, 0);
    tick();
    chk("rd_ack0", ack0, 1);
    chk("rd_ack1", ack1, 0);
    chk("rd_data", rdata0, 4'b1010);
    req0 = 0;
    tick();

    // tie after a port-0 grant: port 1 first
    req0 = 1; addr0 = 4'd1; req1 = 1; addr1 = 4'd2;
    tick();
    chk("tie2_addr_a", mem_addr, 2);
    tick();
    chk("tie2_ack1", ack1, 1);
    chk("tie2_ack0_n", ack0, 0);
    req1 = 0;
    tick();
    tick();
    chk("tie2_addr_b", mem_addr, 1);
    tick();
    chk("tie2_ack0", ack0, 1);
    chk("tie2_rd0", rdata0, 4'b0011);
    req0 = 0;
    tick();

    // port 1 write, inputs change after the IDLE sample
    req1 = 1; we1 = 1; addr1 = 4'd5; wdata1 = 4'b0110;
    tick();
    addr1 = 4'd0; wdata1 = 4'b1001;
    #1;
    chk("wr_wen", mem_wen, 1);
    chk("wr_addr", mem_addr, 5);
    chk("wr_bus", {28'd0, mem_data}, 32'b0110);
    tick();
    chk("wr_ack1", ack1, 1);
    chk("wr_wen_done", mem_wen, 0);
    chk("wr_rd1_kept", rdata1, 4'b1100);
    req1 = 0; we1 = 0;
    tick();
    chk("wr_wen_idle", mem_wen, 0);
    req1 = 1; addr1 = 4'd5;
    tick();
    chk("rb_addr", mem_addr, 5);
    tick();
    chk("rb_ack1", ack1, 1);
    chk("rb_rd1", rdata1, 4'b0110);
    req1 = 0;
    tick();

    // late request: req1 rises during port 0 ACCESS
    req0 = 1; addr0 = 4'd3;
    tick();
    req1 = 1; addr1 = 4'd5;
    tick();
    chk("late_ack0", ack0, 1);
    chk("late_ack1_d", ack1, 0);
    req0 = 0;
    tick();
    chk("late_ack1_i", ack1, 0);
    tick();
    chk("late_ack1_a", ack1, 0);
    chk("late_addr", mem_addr, 5);
    tick();
    chk("late_ack1", ack1, 1);
    chk("late_rd1", rdata1, 4'b0110);
    req1 = 0;
    tick();

    // reset during a write ACCESS
    req0 = 1; we0 = 1; addr0 = 4'd7; wdata0 = 4'b1111;
    tick();
    chk("rw_wen_pre", mem_wen, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_wen_gated", mem_wen, 0);
    req0 = 0; we0 = 0;
    tick();
    chk("rw_no_ack0", ack0, 0);
    tick();
    rst_n = 1'b1;
    chk("rw_ack0", ack0, 0);
    chk("rw_ack1", ack1, 0);
    chk("rw_rdata0", rdata0, 0);
    chk("rw_rdata1", rdata1, 0);
    chk("rw_maddr", mem_addr, 0);
    chk("rw_mwen", mem_wen, 0);
    tick();
    rdata_check7();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic rdata_check7();
    req0 = 1; addr0 = 4'd7; wdata0 = 4'b0101;
    tick();
    chk("r7_addr", mem_addr, 7);
    chk("r7_wen", mem_wen, 0);
    tick();
    chk("r7_ack0", ack0, 1);
    chk("r7_rd0", rdata0, 4'b0000);
    req0 = 0;
    tick();
  endtask

endmodule
